// File: rtl/memoria_instrucciones_param.sv
// Instruction memory for the fetch stage: synchronous read, with a run-time programming port.
// Latency: read data is registered 1 cycle after the address; after reset an init sweep takes DEPTH edges.
// Backpressure: prog_ready stays low during the sweep; leer=0 stalls and holds the output.
// Ports: clk/reset (async, active high); direccion/leer -> instruccion/instruccion_valida (fetch);
//        prog_valid/prog_dir/prog_dato -> prog_ready (programming); listo (sweep done).
module memoria_instrucciones_param #(
  parameter int                 DATA_W    = 32,
  parameter int                 ADDR_W    = 10,
  parameter int                 DEPTH     = 1024,
  parameter logic [DATA_W-1:0]  FILL_WORD = DATA_W'(1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] direccion,
  input  logic              leer,
  output logic [DATA_W-1:0] instruccion,
  output logic              instruccion_valida,
  input  logic              prog_valid,
  input  logic [ADDR_W-1:0] prog_dir,
  input  logic [DATA_W-1:0] prog_dato,
  output logic              prog_ready,
  output logic              listo
);

  // The sweep counter must be able to hold DEPTH-1 (and DEPTH for the sizing rule).
  localparam int CNT_W = ($clog2(DEPTH + 1) < 1) ? 1 : $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly (unsigned).
  localparam logic [ADDR_W:0]  DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] ULTIMO  = CNT_W'(DEPTH - 1);

  typedef enum logic {INIT, RUN} estado_t;

  estado_t           estado_q, estado_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fill_we;
  logic              en_run;
  logic              dir_en_rango;
  logic              prog_en_rango;
  logic              prog_we;
  logic [DATA_W-1:0] rd_dato;

  logic [DATA_W-1:0] mem [DEPTH];

  // Addresses below DEPTH fit in IDX_W bits, so the truncation only drops zero bits.
  function automatic logic [IDX_W-1:0] a_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(a);
  endfunction

  // ---------------------------------------------------------------------
  // Init sweep FSM
  // ---------------------------------------------------------------------
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    fill_we  = 1'b0;
    case (estado_q)
      INIT: begin
        fill_we = 1'b1;
        // The counter stops on the last address rather than wrapping.
        if (cnt_q == ULTIMO) begin
          estado_d = RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        estado_d = RUN;
      end
      default: begin
        estado_d = INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q <= INIT;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
    end
  end

  // listo and prog_ready are decodes of the state register, so they rise on
  // the edge that ends the sweep and drop asynchronously with reset.
  assign en_run     = (estado_q == RUN);
  assign listo      = en_run;
  assign prog_ready = en_run;

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------
  assign dir_en_rango  = ({1'b0, direccion} < DEPTH_X);
  assign prog_en_rango = ({1'b0, prog_dir}  < DEPTH_X);
  // Out-of-range writes still complete the handshake; only the store is dropped.
  assign prog_we       = prog_valid & en_run & prog_en_rango;

  // No reset on the array: the sweep after every reset rewrites it.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      mem[IDX_W'(cnt_q)] <= FILL_WORD;
    end else if (prog_we) begin
      mem[a_idx(prog_dir)] <= prog_dato;
    end
  end

  // Write-first: a fetch of the address being programmed on the same edge
  // returns the new data instead of the stale array contents.
  always_comb begin
    rd_dato = FILL_WORD;
    if (dir_en_rango) begin
      if (prog_we && (prog_dir == direccion)) begin
        rd_dato = prog_dato;
      end else begin
        rd_dato = mem[a_idx(direccion)];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instruccion        <= FILL_WORD;
      instruccion_valida <= 1'b0;
    end else if (en_run && leer) begin
      instruccion        <= rd_dato;
      instruccion_valida <= 1'b1;
    end
  end

endmodule

// File: tb/tb_memoria_instrucciones_param.sv
module tb_memoria_instrucciones_param;

  localparam logic [31:0] FILL = 32'h00000001;

  logic        clk;
  logic        reset;
  logic [3:0]  direccion [2];
  logic        leer      [2];
  logic [31:0] instruccion [2];
  logic        instruccion_valida [2];
  logic        prog_valid [2];
  logic [3:0]  prog_dir   [2];
  logic [31:0] prog_dato  [2];
  logic        prog_ready [2];
  logic        listo      [2];

  int checks = 0;
  int errors = 0;

  // Instance 0: DEPTH 16 (full address space); instance 1: DEPTH 12 (partial).
  memoria_instrucciones_param #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .FILL_WORD(FILL)) dut0 (
    .clk(clk), .reset(reset),
    .direccion(direccion[0]), .leer(leer[0]),
    .instruccion(instruccion[0]), .instruccion_valida(instruccion_valida[0]),
    .prog_valid(prog_valid[0]), .prog_dir(prog_dir[0]), .prog_dato(prog_dato[0]),
    .prog_ready(prog_ready[0]), .listo(listo[0])
  );

  memoria_instrucciones_param #(.DATA_W(32), .ADDR_W(4), .DEPTH(12), .FILL_WORD(FILL)) dut1 (
    .clk(clk), .reset(reset),
    .direccion(direccion[1]), .leer(leer[1]),
    .instruccion(instruccion[1]), .instruccion_valida(instruccion_valida[1]),
    .prog_valid(prog_valid[1]), .prog_dir(prog_dir[1]), .prog_dato(prog_dato[1]),
    .prog_ready(prog_ready[1]), .listo(listo[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dep(input int d);
    return (d == 0) ? 16 : 12;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------
  // Behavioural model: memory is usable after DEPTH edges; a fetch returns
  // the latest data for the address (including a same-edge write).
  // -------------------------------------------------------------------
  logic [31:0] mm    [2][16];
  int          edges [2];
  logic [31:0] m_out [2];
  logic        m_val [2];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        edges[d] <= 0;
        m_val[d] <= 1'b0;
        m_out[d] <= FILL;
        for (int a = 0; a < 16; a++) mm[d][a] <= FILL;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (edges[d] >= dep(d)) begin
          if (prog_valid[d] && int'(prog_dir[d]) < dep(d))
            mm[d][prog_dir[d]] <= prog_dato[d];
          if (leer[d]) begin
            m_val[d] <= 1'b1;
            if (int'(direccion[d]) >= dep(d))
              m_out[d] <= FILL;
            else if (prog_valid[d] && prog_dir[d] == direccion[d])
              m_out[d] <= prog_dato[d];
            else
              m_out[d] <= mm[d][direccion[d]];
          end
        end else begin
          edges[d] <= edges[d] + 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("model_instr%0d", d), instruccion[d], m_out[d]);
        chk($sformatf("model_valid%0d", d), {31'b0, instruccion_valida[d]}, {31'b0, m_val[d]});
        chk($sformatf("model_listo%0d", d), {31'b0, listo[d]}, {31'b0, edges[d] >= dep(d)});
        chk($sformatf("model_ready%0d", d), {31'b0, prog_ready[d]}, {31'b0, edges[d] >= dep(d)});
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic expect_out(input string name, input int d, input logic [31:0] v, input logic vl);
    chk({name, "_instr"}, instruccion[d], v);
    chk({name, "_valid"}, {31'b0, instruccion_valida[d]}, {31'b0, vl});
  endtask

  task automatic expect_reset_vals(input string name);
    for (int d = 0; d < 2; d++) begin
      expect_out(name, d, FILL, 1'b0);
      chk({name, "_listo"}, {31'b0, listo[d]}, 32'd0);
      chk({name, "_ready"}, {31'b0, prog_ready[d]}, 32'd0);
    end
  endtask

  task automatic do_write(input int d, input logic [3:0] a, input logic [31:0] v);
    prog_valid[d] = 1'b1; prog_dir[d] = a; prog_dato[d] = v;
    step();
    prog_valid[d] = 1'b0;
  endtask

  task automatic do_read(input int d, input logic [3:0] a);
    leer[d] = 1'b1; direccion[d] = a;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      direccion[d] = '0; leer[d] = 1'b1;
      prog_valid[d] = 1'b0; prog_dir[d] = '0; prog_dato[d] = '0;
    end
    step(); step();
    expect_reset_vals("reset");
    reset = 1'b0;

    // Init sweep: listo after exactly DEPTH edges, valid one fetch later.
    for (int i = 1; i <= 17; i++) begin
      step();
      chk($sformatf("sweep_listo0_e%0d", i), {31'b0, listo[0]}, {31'b0, i >= 16});
      chk($sformatf("sweep_listo1_e%0d", i), {31'b0, listo[1]}, {31'b0, i >= 12});
      chk($sformatf("sweep_valid0_e%0d", i), {31'b0, instruccion_valida[0]}, {31'b0, i >= 17});
      chk($sformatf("sweep_valid1_e%0d", i), {31'b0, instruccion_valida[1]}, {31'b0, i >= 13});
    end

    for (int a = 0; a < 16; a++) begin
      do_read(0, 4'(a));
      expect_out($sformatf("fill_a%0d", a), 0, FILL, 1'b1);
    end

    // Program and fetch back-to-back.
    leer[0] = 1'b0;
    do_write(0, 4'd0, 32'h20420005);
    do_write(0, 4'd1, 32'h00432020);
    do_read(0, 4'd0);
    expect_out("fetch0", 0, 32'h20420005, 1'b1);
    do_read(0, 4'd1);
    expect_out("fetch1", 0, 32'h00432020, 1'b1);

    // Stall with a changing address.
    leer[0] = 1'b0; direccion[0] = 4'd5;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out($sformatf("stall%0d", i), 0, 32'h00432020, 1'b1);
    end

    // Write-first collision.
    leer[0] = 1'b1; direccion[0] = 4'd12;
    do_write(0, 4'd12, 32'hA0030000);
    expect_out("collision", 0, 32'hA0030000, 1'b1);
    do_read(0, 4'd12);
    expect_out("collision_after", 0, 32'hA0030000, 1'b1);

    // Out of range on the 12-deep instance.
    leer[1] = 1'b0;
    do_write(1, 4'd11, 32'h11110011);
    do_write(1, 4'd13, 32'hDEADBEEF);
    chk("oor_ready", {31'b0, prog_ready[1]}, 32'd1);
    do_read(1, 4'd13);
    expect_out("oor_read13", 1, FILL, 1'b1);
    do_read(1, 4'd11);
    expect_out("oor_read11", 1, 32'h11110011, 1'b1);
    do_read(1, 4'd15);
    expect_out("oor_read15", 1, FILL, 1'b1);

    // Reset while running, then again mid-sweep.
    leer[0] = 1'b0;
    do_write(0, 4'd3, 32'h33333333);
    do_read(0, 4'd3);
    expect_out("prog3", 0, 32'h33333333, 1'b1);
    #2 reset = 1'b1;
    #1 expect_reset_vals("async_reset_run");
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    #2 reset = 1'b1;
    #1 expect_reset_vals("async_reset_sweep");
    step();
    reset = 1'b0;

    // Writes offered during the sweep must not be taken.
    prog_valid[0] = 1'b1; prog_dir[0] = 4'd4; prog_dato[0] = 32'h44444444;
    leer[0] = 1'b1; direccion[0] = 4'd3;
    for (int i = 1; i <= 16; i++) begin
      if (i == 15) prog_valid[0] = 1'b0;
      step();
      if (i < 16) chk($sformatf("init_ready_e%0d", i), {31'b0, prog_ready[0]}, 32'd0);
    end
    chk("reinit_listo", {31'b0, listo[0]}, 32'd1);
    do_read(0, 4'd3);
    expect_out("reinit_a3", 0, FILL, 1'b1);
    do_read(0, 4'd4);
    expect_out("reinit_a4", 0, FILL, 1'b1);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
